spi_master: RTL

- FPGA-side SPI master that speaks the same framed protocol as the FPGA SPI slave.
- Sends driver configuration frames: opcode 0xBF, then 6 config bytes.
- Sends rotation-read frames: opcode 0x4C, then 2 dummy bytes, capturing 2 rotation bytes.
- Used as the bench/loopback initiator for the slave and for FPGA-to-FPGA configuration links; runs off the system clock and generates sck/ss/mosi.

---
 rtl/spi_master.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 framed master for config (0xBF) and rotation-read (0x4C) frames; SPI_MASTER_NORESP_CHECK_EN adds no_response.
`timescale 1ns/1ps
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] cfg_data,
  input  logic        cfg_start,
  input  logic        rot_start,
  output logic        busy,
  output logic        done,
  output logic [15:0] rotation_out,
  output logic        rotation_valid,
`ifdef SPI_MASTER_NORESP_CHECK_EN
  output logic        no_response,
`endif
  output logic        sck,
  output logic        ss,
  output logic        mosi,
  input  logic        miso
);
  localparam int CMAX = CLK_DIV > GAP_CYCLES ? CLK_DIV : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n, byte_cnt, byte_cnt_n;
  logic is_cfg, is_cfg_n;
  logic [55:0] tx, tx_n, frame;
  logic [15:0] rx, rx_n, rot_n;
  logic sck_n, ss_n, mosi_n, busy_n, done_n, rv_n;
  logic half_end, gap_end, last_bit, good;
`ifdef SPI_MASTER_NORESP_CHECK_EN
  logic nr_n;
  assign good = rx != 16'hFFFF;
`else
  assign good = 1'b1;
`endif
  assign frame = cfg_start ? {8'hBF, cfg_data[7:0], cfg_data[15:8], cfg_data[23:16], cfg_data[31:24],
                              cfg_data[39:32], cfg_data[47:40]} : {8'h4C, 48'hFFFF_FFFF_FFFF};
  assign half_end = cnt == CW'(CLK_DIV - 1);
  assign gap_end = cnt == CW'(GAP_CYCLES - 1);
  assign last_bit = &bit_cnt && byte_cnt == (is_cfg ? 3'd6 : 3'd2);
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    byte_cnt_n = byte_cnt;
    is_cfg_n = is_cfg;
    tx_n = tx;
    rx_n = rx;
    rot_n = rotation_out;
    sck_n = sck;
    ss_n = ss;
    mosi_n = mosi;
    busy_n = busy;
    done_n = 1'b0;
    rv_n = 1'b0;
`ifdef SPI_MASTER_NORESP_CHECK_EN
    nr_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (cfg_start || rot_start) begin
          state_n = LOW;
          is_cfg_n = cfg_start;
          tx_n = frame;
          mosi_n = frame[55];
          ss_n = 1'b0;
          busy_n = 1'b1;
          bit_cnt_n = '0;
          byte_cnt_n = '0;
        end
      end
      LOW: if (half_end) begin
        cnt_n = '0;
        sck_n = 1'b1;
        rx_n = byte_cnt != 3'd0 ? {rx[14:0], miso} : rx;
        state_n = HIGH;
      end
      HIGH: if (half_end) begin
        cnt_n = '0;
        sck_n = 1'b0;
        state_n = last_bit ? HOLD : LOW;
        if (!last_bit) begin
          tx_n = tx << 1;
          mosi_n = tx[54];
          bit_cnt_n = bit_cnt + 3'd1;
          byte_cnt_n = &bit_cnt ? byte_cnt + 3'd1 : byte_cnt;
        end
      end
      HOLD: if (half_end) begin
        cnt_n = '0;
        ss_n = 1'b1;
        mosi_n = 1'b1;
        done_n = 1'b1;
        rv_n = !is_cfg && good;
        rot_n = !is_cfg && good ? {rx[7:0], rx[15:8]} : rotation_out;
`ifdef SPI_MASTER_NORESP_CHECK_EN
        nr_n = !is_cfg && !good;
`endif
        state_n = GAP;
      end
      GAP: if (gap_end) begin
        cnt_n = '0;
        busy_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      is_cfg <= 1'b0;
      tx <= '0;
      rx <= '0;
      rotation_out <= '0;
      sck <= 1'b0;
      ss <= 1'b1;
      mosi <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      rotation_valid <= 1'b0;
`ifdef SPI_MASTER_NORESP_CHECK_EN
      no_response <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      is_cfg <= is_cfg_n;
      tx <= tx_n;
      rx <= rx_n;
      rotation_out <= rot_n;
      sck <= sck_n;
      ss <= ss_n;
      mosi <= mosi_n;
      busy <= busy_n;
      done <= done_n;
      rotation_valid <= rv_n;
`ifdef SPI_MASTER_NORESP_CHECK_EN
      no_response <= nr_n;
`endif
    end
  end
endmodule
